prog_clock_divider: RTL and testbench
=====================================

Name: prog_clock_divider

Overview:
- Parametrised successor of the team's fixed 4-bit free-running counter/divider.
- Provides a WIDTH-bit counter with a runtime-programmable modulus, count enable and synchronous clear.
- Outputs: divided clock, terminal-count flag, and a divisor change that takes effect glitch-free at the next wrap.
- Sits between the board clock and slower logic: display scan, debouncers, blink timers.

Parameters:
- WIDTH, 4, counter width; divisor range 1..2^WIDTH.
- DEFAULT_DIV, 0, active divisor after reset; encoded as div_in (0 means 2^WIDTH).
- WRAP_WIDTH, 8, width of wrap_count (only when WRAP_COUNT_EN is defined).

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  count enable; when low, all state holds except pending-divisor capture.
- clear  input  1  synchronous clear, priority over enable.
- div_in  input  WIDTH  requested divisor; value 0 encodes 2^WIDTH.
- div_load  input  1  one-cycle strobe capturing div_in into the pending register.
- counter  output  WIDTH  current count, 0..D-1.
- div_out  output  1  divided clock, registered.
- tc  output  1  high while counter == D-1.
- div_pending  output  1  a loaded divisor is waiting for the next wrap.
- wrap_count  output  WRAP_WIDTH  wrap counter (WRAP_COUNT_EN only).

Behaviour:
- Reset (reset_n low, async):
  - counter=0, div_out=0, div_pending=0.
  - active divisor = DEFAULT_DIV; pending register = DEFAULT_DIV.
  - tc reflects counter==D-1, so tc=1 after reset only if D=1.
- Divisor decode:
  - D = active code, or 2^WIDTH when the code is 0.
  - All comparisons use WIDTH+1-bit arithmetic; no truncation.
- Counting (enable=1, clear=0):
  - counter < D-1: counter+1.
  - counter == D-1: counter → 0 (wrap).
  - Defaults (WIDTH=4, DEFAULT_DIV=0) reproduce the legacy 0..15 wrap with div_out == counter[3].
- div_out:
  - Registered from the next counter value, so it is aligned with counter (no extra lag).
  - High iff next counter ≥ H, where H = D − floor(D/2).
  - Low for ceil(D/2) cycles, high for floor(D/2) cycles.
  - D=1: div_out constant 0, tc constant 1.
- tc: combinational decode of registered counter and active D; no input-to-output path.
- Divisor change:
  - div_load=1 writes div_in to pending and sets div_pending.
  - At the next wrap, or at clear: active ← pending, div_pending ← 0.
  - div_load in the same cycle as a wrap or clear: the new div_in is applied directly and div_pending stays 0.
  - Repeated div_load before a wrap: last value wins.
  - The counter never exceeds the new D-1, because changes apply only at counter=0.
- clear=1:
  - counter=0, div_out=0, pending divisor applied; enable is ignored.
  - wrap_count unaffected.
- enable=0: counter, div_out and active D hold; div_load still captures.
- reset_n asserted mid-count: immediate return to reset values; any pending divisor is discarded.

Optional Feature:
- Macro: WRAP_COUNT_EN.
- Defined:
  - wrap_count port exists; reset 0.
  - Increments by 1 on each wrap (not on clear).
  - Saturates at 2^WRAP_WIDTH−1.
  - Cleared only by reset_n.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Defaults, enable=1 for 32 cycles → counter 0..15,0..15; div_out low for counts 0-7, high for 8-15; tc high at 15 only.
- div_load div_in=5 while counter=3, D=16 → div_pending=1 until wrap; then counter 0..4 repeating; div_out low 3 / high 2; tc at 4.
- D=1 (load 1, then clear) → counter stays 0, tc=1, div_out=0 for 10 cycles.
- enable=0 at counter=9 for 4 cycles, then clear=1 together with enable=1 → hold at 9 with div_out=1; then counter=0, div_out=0 next edge.
- reset_n pulsed low mid-cycle at counter=12 with pending div=7 → outputs zero immediately, before the next edge; D=16 after release; div_pending=0.
- WRAP_COUNT_EN, WRAP_WIDTH=2, D=2, 12 cycles → wrap_count 1,2,3, then held at 3.

Source files
------------

// File: rtl/prog_clock_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : prog_clock_divider                                         |
// | Description : WIDTH-bit counter/clock divider with a runtime-programmable |
// |               modulus (div_in, 0 encodes 2^WIDTH), count enable,         |
// |               synchronous clear, registered divided clock, terminal-     |
// |               count flag and a divisor change that applies at the next   |
// |               wrap. Optional macro WRAP_COUNT_EN adds a saturating       |
// |               wrap counter output (wrap_count).                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module prog_clock_divider #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 0,
  parameter int WRAP_WIDTH  = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic [WIDTH-1:0] counter,
  output logic             div_out,
  output logic             tc,
  output logic             div_pending
`ifdef WRAP_COUNT_EN
  ,
  output logic [WRAP_WIDTH-1:0] wrap_count
`endif
);

  localparam logic [WIDTH-1:0] c_default_code = WIDTH'(DEFAULT_DIV);
  // Divisor value selected by code 0: 2^WIDTH, needs the extra bit.
  localparam logic [WIDTH:0]   c_full_div     = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   c_one_wide     = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] c_one_cnt      = WIDTH'(1);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1) begin : g_width_check
    $error("prog_clock_divider: WIDTH must be at least 1");
  end
  if (WRAP_WIDTH < 1) begin : g_wrap_width_check
    $error("prog_clock_divider: WRAP_WIDTH must be at least 1");
  end
  if ((DEFAULT_DIV < 0) || (DEFAULT_DIV >= (2 ** WIDTH))) begin : g_default_div_check
    $error("prog_clock_divider: DEFAULT_DIV must fit in WIDTH bits");
  end

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             div_out_q, div_out_d;
  logic             pending_q, pending_d;

  logic [WIDTH:0]   w_div;
  logic [WIDTH:0]   w_high_start;
  logic             w_tc;
  logic             w_wrap;
  logic             w_apply;
  logic [WIDTH-1:0] w_apply_code;

  // Decode active divisor, high-phase start point and wrap/apply conditions.
  always_comb begin
    w_div        = (active_q == '0) ? c_full_div : {1'b0, active_q};
    // Low phase gets the odd cycle: low ceil(D/2), high floor(D/2).
    w_high_start = w_div - (w_div >> 1);
    w_tc         = ({1'b0, counter_q} == (w_div - c_one_wide));
    w_wrap       = enable && !clear && w_tc;
    w_apply      = clear || w_wrap;
    // A load coinciding with wrap/clear bypasses the pending register.
    w_apply_code = div_load ? div_in : pend_q;
  end

  // Next-state logic for counter, divided clock and divisor registers.
  always_comb begin
    counter_d = counter_q;
    div_out_d = div_out_q;
    active_d  = active_q;
    pend_d    = div_load ? div_in : pend_q;
    pending_d = pending_q | div_load;

    // Divisor changes only when the count restarts at 0, so the counter
    // can never sit above the new D-1.
    if (w_apply) begin
      active_d  = w_apply_code;
      pending_d = 1'b0;
    end

    if (clear) begin
      counter_d = '0;
      div_out_d = 1'b0;
    end else if (enable) begin
      counter_d = w_tc ? '0 : (counter_q + c_one_cnt);
      // Registered from the next count so div_out lines up with counter.
      div_out_d = ({1'b0, counter_d} >= w_high_start);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter_q <= '0;
      div_out_q <= 1'b0;
      active_q  <= c_default_code;
      pend_q    <= c_default_code;
      pending_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      div_out_q <= div_out_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
    end
  end

  assign counter     = counter_q;
  assign div_out     = div_out_q;
  assign tc          = w_tc;
  assign div_pending = pending_q;

`ifdef WRAP_COUNT_EN
  logic [WRAP_WIDTH-1:0] wrap_count_q, wrap_count_d;

  // Saturating count of wraps; clear does not count as a wrap.
  always_comb begin
    wrap_count_d = wrap_count_q;
    if (w_wrap && (wrap_count_q != '1)) begin
      wrap_count_d = wrap_count_q + WRAP_WIDTH'(1);
    end
  end

  // Wrap counter register, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrap_count_q <= '0;
    end else begin
      wrap_count_q <= wrap_count_d;
    end
  end

  assign wrap_count = wrap_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_clock_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_prog_clock_divider                                      |
// | Description : Directed self-checking bench for prog_clock_divider.       |
// |               Exercises the wrap counter when WRAP_COUNT_EN is defined.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_prog_clock_divider;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       clear;
  logic [3:0] div_in;
  logic       div_load;
  logic [3:0] counter;
  logic       div_out;
  logic       tc;
  logic       div_pending;

  int total;
  int bad;

`ifdef WRAP_COUNT_EN
  logic [1:0] wrap_count;

  prog_clock_divider #(
    .WIDTH      (4),
    .DEFAULT_DIV(0),
    .WRAP_WIDTH (2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .div_in     (div_in),
    .div_load   (div_load),
    .counter    (counter),
    .div_out    (div_out),
    .tc         (tc),
    .div_pending(div_pending),
    .wrap_count (wrap_count)
  );
`else
  prog_clock_divider #(
    .WIDTH      (4),
    .DEFAULT_DIV(0),
    .WRAP_WIDTH (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .div_in     (div_in),
    .div_load   (div_load),
    .counter    (counter),
    .div_out    (div_out),
    .tc         (tc),
    .div_pending(div_pending)
  );
`endif

  // 10-unit clock; rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Runaway guard.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    div_in   = 4'd0;
    div_load = 1'b0;

    // Reset state
    #2;
    check("rst_counter", 32'(counter), 32'd0);
    check("rst_div_out", 32'(div_out), 32'd0);
    check("rst_tc", 32'(tc), 32'd0);
    check("rst_pending", 32'(div_pending), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    enable  = 1'b1;

    // Legacy behaviour: D=16, two full periods
    for (int i = 0; i < 32; i++) begin
      check("leg_counter", 32'(counter), 32'(i % 16));
      check("leg_div_out", 32'(div_out), 32'((i % 16) >= 8));
      check("leg_tc", 32'(tc), 32'((i % 16) == 15));
      step();
    end

    // Load D=5 while counter=3; applies at next wrap
    step(); step(); step();
    check("ld5_pre_counter", 32'(counter), 32'd3);
    div_in   = 4'd5;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    for (int k = 0; k < 11; k++) begin
      check("ld5_counter", 32'(counter), 32'(4 + k));
      check("ld5_pending", 32'(div_pending), 32'd1);
      step();
    end
    check("ld5_tc15", 32'(tc), 32'd1);
    step();
    check("ld5_applied", 32'(div_pending), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("d5_counter", 32'(counter), 32'(i % 5));
      check("d5_div_out", 32'(div_out), 32'((i % 5) >= 3));
      check("d5_tc", 32'(tc), 32'((i % 5) == 4));
      step();
    end

    // D=1 via load then clear
    div_in   = 4'd1;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("d1_pending", 32'(div_pending), 32'd1);
    check("d1_counter_pre", 32'(counter), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("d1_clr_pending", 32'(div_pending), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("d1_counter", 32'(counter), 32'd0);
      check("d1_tc", 32'(tc), 32'd1);
      check("d1_div_out", 32'(div_out), 32'd0);
      step();
    end

    // Load coinciding with clear applies directly (D=16)
    clear    = 1'b1;
    div_load = 1'b1;
    div_in   = 4'd0;
    step();
    clear    = 1'b0;
    div_load = 1'b0;
    check("clrld_pending", 32'(div_pending), 32'd0);
    check("clrld_counter", 32'(counter), 32'd0);
    for (int i = 0; i < 9; i++) step();
    check("hold_pre_counter", 32'(counter), 32'd9);
    check("hold_pre_div_out", 32'(div_out), 32'd1);

    // Hold with enable=0; loads still captured, last one wins
    enable = 1'b0;
    for (int j = 0; j < 4; j++) begin
      div_load = (j < 2);
      div_in   = (j == 0) ? 4'd3 : 4'd6;
      step();
      check("hold_counter", 32'(counter), 32'd9);
      check("hold_div_out", 32'(div_out), 32'd1);
      check("hold_pending", 32'(div_pending), 32'd1);
    end
    div_load = 1'b0;
    clear    = 1'b1;
    enable   = 1'b1;
    step();
    clear = 1'b0;
    check("clr_counter", 32'(counter), 32'd0);
    check("clr_div_out", 32'(div_out), 32'd0);
    check("clr_pending", 32'(div_pending), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("d6_counter", 32'(counter), 32'(i % 6));
      check("d6_div_out", 32'(div_out), 32'((i % 6) >= 3));
      check("d6_tc", 32'(tc), 32'((i % 6) == 5));
      step();
    end

    // Async reset mid-count at counter=12 with a pending divisor
    clear    = 1'b1;
    div_load = 1'b1;
    div_in   = 4'd0;
    step();
    clear    = 1'b0;
    div_load = 1'b0;
    for (int i = 0; i < 11; i++) step();
    div_in   = 4'd7;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("rst2_pre_counter", 32'(counter), 32'd12);
    check("rst2_pre_pending", 32'(div_pending), 32'd1);
    check("rst2_pre_div_out", 32'(div_out), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst2_counter", 32'(counter), 32'd0);
    check("rst2_div_out", 32'(div_out), 32'd0);
    check("rst2_pending", 32'(div_pending), 32'd0);
    check("rst2_tc", 32'(tc), 32'd0);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("rst2_d16_counter", 32'(counter), 32'(i));
      check("rst2_d16_tc", 32'(tc), 32'(i == 15));
      step();
    end

`ifdef WRAP_COUNT_EN
    // Saturating wrap counter, WRAP_WIDTH=2, D=2
    reset_n = 1'b0;
    #1;
    check("wc_rst", 32'(wrap_count), 32'd0);
    reset_n  = 1'b1;
    clear    = 1'b1;
    div_load = 1'b1;
    div_in   = 4'd2;
    step();
    clear    = 1'b0;
    div_load = 1'b0;
    check("wc_after_clear", 32'(wrap_count), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("wc_count", 32'(wrap_count), 32'(((k / 2) > 3) ? 3 : (k / 2)));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
